dram_arb_refresh_ctrl: RTL

Two-port arbiter and refresh sequencer for the 8×4-bit DRAM model. Shares the single DRAM port between two requesters using round-robin arbitration. Periodically inserts a full-array refresh sweep, which reads each row and writes it back. Sits between the requester logic and the DRAM. The DRAM's bidirectional data bus is split here into in, out and output-enable signals, and the tri-state resolution happens at the level above.

---
 rtl/dram_pkg.sv | 19 +
 rtl/dram_arb_refresh_ctrl_timer.sv | 37 +++
 rtl/dram_arb_refresh_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dram_pkg.sv
// Shared types for the DRAM arbiter / refresh slice.
// Default geometry, FSM state encoding and the requester port id.
package dram_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC_WR,
    S_ACC_RD,
    S_RD_CAP,
    S_REF_RD,
    S_REF_WR
  } state_t;

  typedef logic port_t;

endpackage

// File: rtl/dram_arb_refresh_ctrl_timer.sv
// Free-running refresh interval counter.
// Raises ref_pending on each wrap; the sweep FSM clears it when done.
module refresh_timer
  import dram_pkg::*;
#(
  parameter int INTERVAL = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_pending,
  output logic ref_pending
);

  localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_pending;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(INTERVAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap)
        r_pending <= 1'b1;
      else if (clr_pending)
        r_pending <= 1'b0;
    end
  end

  assign ref_pending = r_pending;

endmodule

// File: rtl/dram_arb_refresh_ctrl.sv
// Round-robin two-port DRAM arbiter with periodic read/write-back
// refresh sweep. Memory-side outputs are registered from next state.
module dram_arb_refresh_ctrl
  import dram_pkg::*;
#(
  parameter int ADDR_W           = ADDR_W_DEF,
  parameter int DATA_W           = DATA_W_DEF,
  parameter int REFRESH_INTERVAL = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_wr,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we_n,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              refresh_busy
);

  state_t              r_state, w_nxt;
  port_t               r_last, r_port, w_gnt;
  logic [ADDR_W-1:0]   r_addr, r_row, w_row_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata;
  logic                r_mem_we_n, w_mem_we_n;
  logic                r_mem_oe, w_mem_oe;
  logic [1:0]          r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_busy;
  logic                w_pending, w_clr, w_acc;
  logic                w_sel_wr;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [1:0]          w_ready;

  refresh_timer #(
    .INTERVAL(REFRESH_INTERVAL)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr_pending(w_clr),
    .ref_pending(w_pending)
  );

  always_comb begin
    w_gnt = 1'b0;
    unique case (req_valid)
      2'b10:   w_gnt = 1'b1;
      2'b11:   w_gnt = ~r_last;
      default: w_gnt = 1'b0;
    endcase
  end

  assign w_ready = (r_state == S_IDLE && !w_pending && |req_valid)
                 ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
  assign w_acc       = |w_ready;
  assign req_ready   = w_ready;
  assign w_sel_wr    = w_gnt ? req_wr[1]  : req_wr[0];
  assign w_sel_addr  = w_gnt ? req_addr1  : req_addr0;
  assign w_sel_wdata = w_gnt ? req_wdata1 : req_wdata0;

  always_comb begin
    w_nxt     = r_state;
    w_row_nxt = r_row;
    w_clr     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_pending) begin
          w_nxt     = S_REF_RD;
          w_row_nxt = '0;
        end else if (w_acc) begin
          w_nxt = w_sel_wr ? S_ACC_WR : S_ACC_RD;
        end
      end
      S_ACC_WR: w_nxt = S_IDLE;
      S_ACC_RD: w_nxt = S_RD_CAP;
      S_RD_CAP: w_nxt = S_IDLE;
      S_REF_RD: w_nxt = S_REF_WR;
      S_REF_WR: begin
        if (r_row == '1) begin
          w_nxt = S_IDLE;
          w_clr = 1'b1;
        end else begin
          w_nxt     = S_REF_RD;
          w_row_nxt = r_row + 1'b1;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Refresh write-back data is taken straight off the bus at REF_RD end.
  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_oe    = 1'b0;
    w_mem_we_n  = 1'b1;
    unique case (w_nxt)
      S_ACC_WR: begin
        w_mem_addr  = w_sel_addr;
        w_mem_wdata = w_sel_wdata;
        w_mem_oe    = 1'b1;
        w_mem_we_n  = 1'b0;
      end
      S_ACC_RD: w_mem_addr = w_sel_addr;
      S_RD_CAP: w_mem_addr = r_addr;
      S_REF_RD: w_mem_addr = w_row_nxt;
      S_REF_WR: begin
        w_mem_addr  = r_row;
        w_mem_wdata = mem_rdata;
        w_mem_oe    = 1'b1;
        w_mem_we_n  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_port      <= 1'b0;
      r_addr      <= '0;
      r_row       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_oe    <= 1'b0;
      r_mem_we_n  <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_nxt;
      r_row       <= w_row_nxt;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_mem_oe    <= w_mem_oe;
      r_mem_we_n  <= w_mem_we_n;
      r_busy      <= (w_nxt == S_REF_RD) || (w_nxt == S_REF_WR);
      r_rsp_valid <= '0;
      if (w_acc) begin
        r_port <= w_gnt;
        r_last <= w_gnt;
        r_addr <= w_sel_addr;
      end
      if (r_state == S_RD_CAP) begin
        r_rsp_valid[r_port] <= 1'b1;
        r_rsp_rdata         <= mem_rdata;
      end
    end
  end

  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_oe       = r_mem_oe;
  assign mem_we_n     = r_mem_we_n;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign refresh_busy = r_busy;

endmodule
